// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for the two-port memory arbiter: data port 0, fetch port 1,
// and the shared synchronous-RAM side.
interface mem_bus_arbiter_if;
  logic        Req0, We0, Ack0;
  logic [31:0] Addr0, WData0, RData0;
  logic        Req1, Ack1;
  logic [31:0] Addr1, RData1;
  logic        MemEn, MemWe;
  logic [31:0] MemAddr, MemWData, MemRData;
  logic        Err;

  modport slave (
    input  Req0, We0, Addr0, WData0, Req1, Addr1, MemRData,
    output RData0, Ack0, RData1, Ack1, MemEn, MemWe, MemAddr, MemWData, Err
  );

  modport master (
    output Req0, We0, Addr0, WData0, Req1, Addr1, MemRData,
    input  RData0, Ack0, RData1, Ack1, MemEn, MemWe, MemAddr, MemWData, Err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter onto one synchronous RAM: IDLE -> ACCESS -> RESP, one
// access per two cycles, data port favoured but bounded by MAX_CONSEC.
module mem_bus_arbiter #(
  parameter int MAX_CONSEC = 2
) (
  input  logic             clk,
  input  logic             rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam int            CW   = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic [CW-1:0] consec_q, consec_d;
  logic          gnt, gnt_id, misal;
  logic [31:0]   rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      consec_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      consec_q <= consec_d;
    end
  end

  // Arbitration runs in IDLE and RESP so a waiting request chains straight
  // into the next ACCESS without an idle bubble.
  assign gnt    = (state_q != ACCESS) && (bus.Req0 || bus.Req1);
  assign gnt_id = bus.Req1 && (!bus.Req0 || consec_q == CMAX);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    consec_d = consec_q;
    unique case (state_q)
      ACCESS:  state_d = RESP;
      default: state_d = gnt ? ACCESS : IDLE;
    endcase
    if (gnt) begin
      req_d.id    = gnt_id;
      req_d.we    = gnt_id ? 1'b0 : bus.We0;
      req_d.addr  = gnt_id ? bus.Addr1 : bus.Addr0;
      req_d.wdata = gnt_id ? 32'h0 : bus.WData0;
    end
    if (!bus.Req1 || (gnt && gnt_id))
      consec_d = '0;
    else if (gnt && consec_q != CMAX)
      consec_d = consec_q + CW'(1);
  end

  // A misaligned access never reaches the RAM; it only reports Err on Ack.
  assign misal = req_q.addr[1:0] != 2'b00;
  assign rdata = (misal || req_q.we) ? 32'h0 : bus.MemRData;

  always_comb begin
    bus.MemEn    = 1'b0;
    bus.MemWe    = 1'b0;
    bus.MemAddr  = 32'h0;
    bus.MemWData = 32'h0;
    bus.Ack0     = 1'b0;
    bus.Ack1     = 1'b0;
    bus.Err      = 1'b0;
    bus.RData0   = 32'h0;
    bus.RData1   = 32'h0;
    case (state_q)
      ACCESS: begin
        bus.MemEn    = !misal;
        bus.MemWe    = req_q.we && !misal;
        bus.MemAddr  = req_q.addr;
        bus.MemWData = req_q.wdata;
      end
      RESP: begin
        bus.Ack0   = !req_q.id;
        bus.Ack1   = req_q.id;
        bus.Err    = misal;
        bus.RData0 = req_q.id ? 32'h0 : rdata;
        bus.RData1 = req_q.id ? rdata : 32'h0;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + random bench for mem_bus_arbiter against a transaction-level
// model (grant -> memory cycle one clock later -> ack the clock after).
module tb_mem_bus_arbiter;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.MAX_CONSEC(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: cycles since grant (0 none, 1 memory cycle, 2 ack cycle)
  int          m_since  = 0;
  int          m_consec = 0;
  logic        m_id, m_we;
  logic [31:0] m_addr, m_wdata;

  int          mode0 = 0, mode1 = 0;  // 0 manual, 1 drop on ack, 2 hold, 3 random
  int          obs_acks[$];
  logic [31:0] last_rd;
  logic        last_err;
  int          exp37[6] = '{0, 0, 1, 0, 0, 1};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_since  = 0;
    m_consec = 0;
    m_id = 1'b0; m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
  endtask

  task automatic check(output bit a0, output bit a1);
    bit          al, acc, rsp;
    logic [31:0] erd;
    al  = (m_addr[1:0] == 2'b00);
    acc = (m_since == 1);
    rsp = (m_since == 2);
    erd = (rsp && al && !m_we) ? bus.MemRData : 32'h0;
    chk("mem", 160'({bus.MemEn, bus.MemWe, bus.MemAddr, bus.MemWData}),
        160'({acc && al, acc && al && m_we, acc ? m_addr : 32'h0, acc ? m_wdata : 32'h0}));
    chk("ack_err", 160'({bus.Ack0, bus.Ack1, bus.Err}),
        160'({rsp && !m_id, rsp && m_id, rsp && !al}));
    chk("rdata", 160'({bus.RData0, bus.RData1}),
        160'({(rsp && !m_id) ? erd : 32'h0, (rsp && m_id) ? erd : 32'h0}));
    a0 = rsp && !m_id;
    a1 = rsp && m_id;
    if (bus.Ack0) begin obs_acks.push_back(0); last_rd = bus.RData0; last_err = bus.Err; end
    if (bus.Ack1) begin obs_acks.push_back(1); last_rd = bus.RData1; last_err = bus.Err; end
  endtask

  task automatic model_edge();
    bit g, w1;
    g  = (m_since != 1) && (bus.Req0 || bus.Req1);
    w1 = bus.Req1 && (!bus.Req0 || m_consec >= MAX);
    if (!bus.Req1 || (g && w1)) m_consec = 0;
    else if (g && m_consec < MAX) m_consec++;
    if (m_since == 1) m_since = 2;
    else if (g) begin
      m_since = 1;
      m_id    = w1;
      m_we    = w1 ? 1'b0 : bus.We0;
      m_addr  = w1 ? bus.Addr1 : bus.Addr0;
      m_wdata = w1 ? 32'h0 : bus.WData0;
    end else m_since = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(4) == 0) a[1:0] = 2'($urandom_range(3, 1));
    return a;
  endfunction

  task automatic new_req0();
    bus.Req0 = 1'b1; bus.We0 = 1'($urandom_range(1));
    bus.Addr0 = rnd_addr(); bus.WData0 = $urandom;
  endtask

  task automatic new_req1();
    bus.Req1 = 1'b1; bus.Addr1 = rnd_addr();
  endtask

  task automatic agent0(input bit ack);
    case (mode0)
      1: if (ack) bus.Req0 = 1'b0;
      3: begin
        if (bus.Req0 && ack) begin
          if ($urandom_range(1) == 1) new_req0(); else bus.Req0 = 1'b0;
        end else if (!bus.Req0 && $urandom_range(9) < 3) new_req0();
        else if (bus.Req0 && m_since == 1 && !m_id && $urandom_range(9) == 0) bus.Req0 = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic agent1(input bit ack);
    case (mode1)
      1: if (ack) bus.Req1 = 1'b0;
      2: if (ack) bus.Addr1 = bus.Addr1 + 32'd4;
      3: begin
        if (bus.Req1 && ack) begin
          if ($urandom_range(1) == 1) new_req1(); else bus.Req1 = 1'b0;
        end else if (!bus.Req1 && $urandom_range(9) < 3) new_req1();
        else if (bus.Req1 && m_since == 1 && m_id && $urandom_range(9) == 0) bus.Req1 = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    bit a0, a1;
    @(negedge clk);
    check(a0, a1);
    agent0(a0);
    agent1(a1);
    model_edge();
    @(posedge clk);
    #1 bus.MemRData = $urandom;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Req0 = 1'b0; bus.We0 = 1'b0; bus.Addr0 = 32'h0; bus.WData0 = 32'h0;
    bus.Req1 = 1'b0; bus.Addr1 = 32'h0; bus.MemRData = 32'h0;
    last_rd = 32'h0; last_err = 1'b0;
    model_reset();

    // reset forces outputs low without a clock edge
    #1 rst = 1'b1;
    #1 chk("reset_outs", 160'({bus.MemEn, bus.MemWe, bus.MemAddr, bus.MemWData, bus.Ack0,
                               bus.Ack1, bus.Err, bus.RData0, bus.RData1}), 160'(0));

    // single read, first arbitration on first edge after reset release
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'h1001_0004; mode0 = 1;
    @(posedge clk); #1 rst = 1'b0;
    tick(); tick();
    bus.MemRData = 32'hDEB1_0000;
    tick();
    chk("r035_nack", 160'(obs_acks.size()), 160'(1));
    chk("r035_rdata", 160'(last_rd), 160'(32'hDEB1_0000));
    ticks(2);

    // write
    obs_acks.delete();
    bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'h1001_0040; bus.WData0 = 32'hF1FA_000B;
    ticks(3);
    chk("r036_nack", 160'(obs_acks.size()), 160'(1));
    chk("r036_err", 160'(last_err), 160'(0));
    ticks(1);

    // contention: grant order 0,0,1 repeating
    obs_acks.delete();
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'h1001_0000; mode0 = 2;
    bus.Req1 = 1'b1; bus.Addr1 = 32'h0040_0000; mode1 = 2;
    ticks(13);
    chk("r037_nack", 160'(obs_acks.size()), 160'(6));
    for (int i = 0; i < 6 && i < obs_acks.size(); i++)
      chk($sformatf("r037_order%0d", i), 160'(obs_acks[i]), 160'(exp37[i]));
    bus.Req0 = 1'b0; bus.Req1 = 1'b0; mode0 = 0; mode1 = 0;
    ticks(3);

    // misaligned fetch
    obs_acks.delete();
    bus.Req1 = 1'b1; bus.Addr1 = 32'h0040_0002; mode1 = 1;
    ticks(3);
    chk("r038_nack", 160'(obs_acks.size()), 160'(1));
    chk("r038_err", 160'(last_err), 160'(1));
    chk("r038_rdata", 160'(last_rd), 160'(0));
    ticks(1);

    // reset during the memory cycle of a write
    obs_acks.delete();
    bus.Req0 = 1'b1; bus.We0 = 1'b1; bus.Addr0 = 32'h1001_0100; bus.WData0 = $urandom; mode0 = 1;
    tick();
    chk("r039_pre", 160'({bus.MemEn, bus.MemWe}), 160'(2'b11));
    #1 rst = 1'b1;
    #1 chk("r039_abort", 160'({bus.MemEn, bus.MemWe, bus.Ack0, bus.Ack1}), 160'(0));
    bus.Req0 = 1'b0; mode0 = 0;
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    ticks(3);
    chk("r039_noack", 160'(obs_acks.size()), 160'(0));
    bus.Req0 = 1'b1; bus.We0 = 1'b0; bus.Addr0 = 32'h1001_0104; mode0 = 1;
    ticks(3);
    chk("r039_after", 160'(obs_acks.size()), 160'(1));
    ticks(1);

    // fetch alone, address stepping per ack
    obs_acks.delete();
    bus.Req1 = 1'b1; bus.Addr1 = 32'h0040_0000; mode1 = 2;
    ticks(7);
    chk("r040_nack", 160'(obs_acks.size()), 160'(3));
    chk("r040_addr", 160'(bus.Addr1), 160'(32'h0040_000C));
    bus.Req1 = 1'b0; mode1 = 0;
    ticks(3);

    // random traffic on both ports
    mode0 = 3; mode1 = 3;
    ticks(1500);
    mode0 = 0; mode1 = 0; bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
